// File: rtl/pipe_stage_hs_if.sv
// Handshake bundle between a pipe_stage_hs instance and its neighbours.
// slave is the stage's own view of the bundle; master is the view of whoever drives it.
interface pipe_stage_hs_if #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        level;

    modport slave (
        input  flush, in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, level
    );

    modport master (
        output flush, in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, level
    );
endinterface

// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with a valid/ready handshake, synchronous flush and an optional skid entry.
// state | meaning
// EMPTY | no beat held, level 0
// BUSY  | main holds the beat on out_*, level 1
// FULL  | main on out_*, skid holds the next beat, level 2 (SKID=1 only)
module pipe_stage_hs #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic            clk,
    input  logic            rst,
    pipe_stage_hs_if.slave  bus
);
    typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;

    state_t            state;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              out_valid_q;
    logic [1:0]        level_q;
    logic              in_ready_q;
    logic              in_ready;
    logic              in_fire;
    logic              out_fire;

    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign in_ready = !out_valid_q | bus.out_ready;
        end
    endgenerate

    assign in_fire  = bus.in_valid & in_ready;
    assign out_fire = out_valid_q & bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= EMPTY;
            main_data   <= '0;
            main_ctrl   <= '0;
            skid_data   <= '0;
            skid_ctrl   <= '0;
            out_valid_q <= 1'b0;
            level_q     <= 2'd0;
            in_ready_q  <= 1'b1;
        end else if (bus.flush) begin
            // Payload registers keep their contents; they are invalid until reloaded.
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            level_q     <= 2'd0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_data   <= bus.in_data;
                        main_ctrl   <= bus.in_ctrl;
                        state       <= BUSY;
                        out_valid_q <= 1'b1;
                        level_q     <= 2'd1;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_data <= bus.in_data;
                        main_ctrl <= bus.in_ctrl;
                    end else if (in_fire) begin
                        // Only reachable with SKID=1: without skid, in_fire in BUSY implies out_fire.
                        skid_data  <= bus.in_data;
                        skid_ctrl  <= bus.in_ctrl;
                        state      <= FULL;
                        level_q    <= 2'd2;
                        in_ready_q <= 1'b0;
                    end else if (out_fire) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                        level_q     <= 2'd0;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_data  <= skid_data;
                        main_ctrl  <= skid_ctrl;
                        state      <= BUSY;
                        level_q    <= 2'd1;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                    level_q     <= 2'd0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_data;
    assign bus.out_ctrl  = out_valid_q ? main_ctrl : '0;
    assign bus.level     = level_q;
endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs: one skid instance and one single-register instance
// sharing clock and reset.
module tb_pipe_stage_hs;
    localparam int DW = 64;
    localparam int CW = 8;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    pipe_stage_hs_if #(.DATA_W(DW), .CTRL_W(CW)) if1 ();
    pipe_stage_hs_if #(.DATA_W(DW), .CTRL_W(CW)) if0 ();

    pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic v, input logic [63:0] d, input logic [7:0] c);
        if1.in_valid = v;
        if1.in_data  = d;
        if1.in_ctrl  = c;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b0;
        if1.flush = 1'b0; if1.out_ready = 1'b0;
        if0.flush = 1'b0; if0.out_ready = 1'b0;
        if0.in_valid = 1'b0; if0.in_data = '0; if0.in_ctrl = '0;
        drive1(1'b1, 64'hDEAD, 8'hFF);

        // reset held two cycles with a beat offered
        tick();
        tick();
        chk("rst_out_valid", if1.out_valid, 1'b0);
        chk("rst_out_ctrl",  if1.out_ctrl,  8'h00);
        chk("rst_out_data",  if1.out_data,  64'h0);
        chk("rst_level",     if1.level,     2'd0);
        chk("rst0_out_valid", if0.out_valid, 1'b0);
        rst = 1'b1;
        drive1(1'b0, 64'h0, 8'h00);
        tick();
        chk("post_rst_in_ready",  if1.in_ready,  1'b1);
        chk("post_rst_out_valid", if1.out_valid, 1'b0);

        // streaming, 1-cycle latency
        if1.out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            drive1(1'b1, 64'(i), 8'(i));
            chk("stream_in_ready", if1.in_ready, 1'b1);
            tick();
            chk("stream_out_valid", if1.out_valid, 1'b1);
            chk("stream_out_data",  if1.out_data,  64'(i));
            chk("stream_out_ctrl",  if1.out_ctrl,  64'(i));
            chk("stream_level",     if1.level,     2'd1);
        end
        drive1(1'b0, 64'h0, 8'h00);
        tick();
        chk("stream_drain_level", if1.level, 2'd0);
        chk("stream_drain_ctrl",  if1.out_ctrl, 8'h00);

        // back-pressure: A, B, C with out_ready low
        if1.out_ready = 1'b0;
        drive1(1'b1, 64'hA, 8'h11);
        tick();
        chk("bp_a_level",    if1.level,    2'd1);
        chk("bp_a_data",     if1.out_data, 64'hA);
        chk("bp_a_in_ready", if1.in_ready, 1'b1);
        drive1(1'b1, 64'hB, 8'h22);
        tick();
        chk("bp_b_level",    if1.level,    2'd2);
        chk("bp_b_in_ready", if1.in_ready, 1'b0);
        chk("bp_b_hold",     if1.out_data, 64'hA);
        drive1(1'b1, 64'hC, 8'h33);
        tick();
        chk("bp_c_level",    if1.level,    2'd2);
        chk("bp_c_hold",     if1.out_data, 64'hA);
        chk("bp_c_hold_ctl", if1.out_ctrl, 8'h11);
        chk("bp_c_in_ready", if1.in_ready, 1'b0);
        if1.out_ready = 1'b1;
        tick();
        chk("bp_out_b",      if1.out_data, 64'hB);
        chk("bp_out_b_ctl",  if1.out_ctrl, 8'h22);
        chk("bp_out_b_lvl",  if1.level,    2'd1);
        chk("bp_out_b_rdy",  if1.in_ready, 1'b1);
        tick();
        chk("bp_out_c",      if1.out_data, 64'hC);
        chk("bp_out_c_ctl",  if1.out_ctrl, 8'h33);
        chk("bp_out_c_lvl",  if1.level,    2'd1);
        drive1(1'b0, 64'h0, 8'h00);
        tick();
        chk("bp_empty_valid", if1.out_valid, 1'b0);
        chk("bp_empty_level", if1.level,     2'd0);

        // flush while FULL, with beat D offered
        if1.out_ready = 1'b0;
        drive1(1'b1, 64'h100, 8'h44);
        tick();
        drive1(1'b1, 64'h200, 8'h55);
        tick();
        chk("fl_full_level", if1.level, 2'd2);
        if1.flush = 1'b1;
        drive1(1'b1, 64'h400, 8'h66);
        tick();
        chk("fl_out_valid", if1.out_valid, 1'b0);
        chk("fl_out_ctrl",  if1.out_ctrl,  8'h00);
        chk("fl_level",     if1.level,     2'd0);
        chk("fl_in_ready",  if1.in_ready,  1'b1);
        if1.flush = 1'b0;
        if1.out_ready = 1'b1;
        drive1(1'b0, 64'h0, 8'h00);
        tick();
        chk("fl_no_ghost_valid", if1.out_valid, 1'b0);
        tick();
        chk("fl_no_ghost_level", if1.level, 2'd0);

        // reset mid-transfer while FULL, with flush and out_ready also high
        if1.out_ready = 1'b0;
        drive1(1'b1, 64'h1A, 8'h77);
        tick();
        drive1(1'b1, 64'h1B, 8'h88);
        tick();
        chk("rm_full_level", if1.level, 2'd2);
        rst = 1'b0;
        if1.flush = 1'b1;
        if1.out_ready = 1'b1;
        tick();
        chk("rm_out_valid", if1.out_valid, 1'b0);
        chk("rm_out_data",  if1.out_data,  64'h0);
        chk("rm_out_ctrl",  if1.out_ctrl,  8'h00);
        chk("rm_level",     if1.level,     2'd0);
        chk("rm_in_ready",  if1.in_ready,  1'b1);
        rst = 1'b1;
        if1.flush = 1'b0;
        drive1(1'b1, 64'hE0E, 8'h99);
        tick();
        chk("rm_e_valid", if1.out_valid, 1'b1);
        chk("rm_e_data",  if1.out_data,  64'hE0E);
        chk("rm_e_ctrl",  if1.out_ctrl,  8'h99);
        drive1(1'b0, 64'h0, 8'h00);
        tick();
        chk("rm_e_drain", if1.level, 2'd0);

        // SKID=0 instance: combinational in_ready
        if0.out_ready = 1'b0;
        if0.in_valid  = 1'b1;
        if0.in_data   = 64'h55;
        if0.in_ctrl   = 8'h5A;
        #1;
        chk("s0_empty_in_ready", if0.in_ready, 1'b1);
        tick();
        chk("s0_x_valid", if0.out_valid, 1'b1);
        chk("s0_x_data",  if0.out_data,  64'h55);
        chk("s0_in_ready_low", if0.in_ready, 1'b0);
        if0.in_data = 64'h66;
        if0.in_ctrl = 8'h6B;
        tick();
        chk("s0_hold_level", if0.level,    2'd1);
        chk("s0_hold_data",  if0.out_data, 64'h55);
        chk("s0_hold_ctrl",  if0.out_ctrl, 8'h5A);
        if0.out_ready = 1'b1;
        #1;
        chk("s0_in_ready_comb", if0.in_ready, 1'b1);
        tick();
        chk("s0_y_data",  if0.out_data, 64'h66);
        chk("s0_y_ctrl",  if0.out_ctrl, 8'h6B);
        chk("s0_y_level", if0.level,    2'd1);
        if0.in_valid = 1'b0;
        tick();
        chk("s0_drain_level", if0.level,    2'd0);
        chk("s0_drain_ctrl",  if0.out_ctrl, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_stage_hs.md
Name: pipe_stage_hs

Overview:
- Parametrised pipeline stage register: the next-generation replacement for the fixed per-signal dff_pipe stage banks (IF/ID … MEM/WB).
- One instance carries a full payload bus: data plus control bits.
- Adds a valid/ready handshake, synchronous flush, and an optional two-entry skid buffer, so back-pressure does not form a combinational ready path through the pipeline.
- Sits between any two pipeline stages of the 16-bit core.

Parameters:
- DATA_W, 64: width of the datapath payload (e.g. alu_out, pc_add2, memData, branchAddr concatenated).
- CTRL_W, 8: width of the control payload (REGWRITE, MEMTOREG, HALT, …); forced to zero on bubbles.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-low (0 = reset on the next rising edge of clk).
- flush  input  1  synchronous flush: kill all held beats and the incoming beat.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  stage can accept a beat this cycle.
- in_data  input  DATA_W  upstream datapath payload.
- in_ctrl  input  CTRL_W  upstream control payload.
- out_valid  output  1  downstream beat present.
- out_ready  input  1  downstream accepts the beat this cycle.
- out_data  output  DATA_W  held datapath payload.
- out_ctrl  output  CTRL_W  held control payload; all zero when out_valid=0.
- level  output  2  beats held: 0, 1 or 2 (2 only when SKID=1).

Behaviour:
- Handshake definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Beats are never duplicated, dropped (except by flush) or reordered.
- Reset (rst=0 at a clock edge):
  - State goes to EMPTY.
  - out_valid=0, out_ctrl=0, out_data=0, skid registers=0, level=0.
  - in_ready=1 from the first cycle after reset (SKID=1).
  - Reset overrides flush and every handshake, including mid-transfer.
- Latency and throughput:
  - Latency is 1 cycle: a beat accepted at edge N is presented on out_* after edge N.
  - Sustained throughput is 1 beat/cycle while out_ready=1.
- SKID=1 state machine (registers: main, skid):
  - EMPTY (level 0, in_ready=1): in_fire -> BUSY, main<=in; otherwise stay.
  - BUSY (level 1, in_ready=1):
    - in_fire & out_fire -> BUSY, main<=in.
    - in_fire & !out_fire -> FULL, skid<=in.
    - !in_fire & out_fire -> EMPTY.
    - Neither -> stay.
  - FULL (level 2, in_ready=0): out_fire -> BUSY, main<=skid; otherwise stay with main held stable.
  - in_ready is a flop output equal to (next state != FULL). It has no combinational path from out_ready.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - in_fire loads main; out_fire without in_fire empties it.
  - FULL is unreachable; level is at most 1.
- Flush (rst=1, flush=1 at an edge):
  - Next state is EMPTY; out_valid=0, out_ctrl=0, level=0.
  - The in_* beat in the flush cycle is discarded even if in_fire would be 1.
  - out_data and skid data hold their old values (they are don't-care while invalid).
  - in_ready=1 on the following cycle.
  - If out_fire and flush occur in the same cycle, the downstream consumes the beat; the stage still empties.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_ctrl must not change.
- Bubbles: out_ctrl is gated to zero whenever out_valid=0, so a bubble is a NOP downstream (REGWRITE/HALT inactive).
- Payload passes through unmodified: no arithmetic, no width conversion.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1, in_ctrl=8'hFF -> out_valid=0, out_ctrl=0, out_data=0, level=0; in_ready=1 the cycle after rst=1.
- Streaming: send beats data 0x0001..0x0010 back-to-back with out_ready=1 -> each appears exactly 1 cycle later, in order; in_ready stays 1; level=1 throughout.
- Back-pressure (SKID=1):
  - Send A, B, C with out_ready=0 -> level goes 1 then 2; in_ready=0 after B, C is not accepted.
  - out holds A stably.
  - Raise out_ready -> outputs A, B, C in order, no loss.
- Flush while FULL: state FULL holding A, B; pulse flush with in_valid=1 (beat D) -> next cycle out_valid=0, out_ctrl=0, level=0, in_ready=1; neither D nor B ever appears.
- Reset mid-transfer: in FULL, drive rst=0 together with flush=1 and out_ready=1 -> all outputs take their reset values; a subsequent beat E passes with 1-cycle latency.
- SKID=0 instance: out_valid=1, out_ready=0 -> in_ready=0 in the same cycle; set out_ready=1 -> in_ready=1 combinationally, and simultaneous in/out fires keep level=1.
